// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with colour, sync and blank registered one pixel behind the coordinates.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [7:0] iRed,
  input  logic [7:0] iGreen,
  input  logic [7:0] iBlue,
  output logic [9:0] oCoord_X,
  output logic [9:0] oCoord_Y,
  output logic [7:0] oVGA_R,
  output logic [7:0] oVGA_G,
  output logic [7:0] oVGA_B,
  output logic       oVGA_H_SYNC,
  output logic       oVGA_V_SYNC,
  output logic       oVGA_SYNC,
  output logic       oVGA_BLANK,
  output logic       oFrame_start
);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  logic [9:0] h_cnt, v_cnt;
  logic h_last, v_last, visible, h_sync_n, v_sync_n;
  assign h_last   = h_cnt == H_LAST;
  assign v_last   = v_cnt == V_LAST;
  assign visible  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign h_sync_n = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign v_sync_n = !((v_cnt >= V_SS) && (v_cnt < V_SE));
  assign oCoord_X  = h_cnt;
  assign oCoord_Y  = v_cnt;
  assign oVGA_SYNC = 1'b0;
  // outputs sample the pre-increment position so colour, sync and blank stay aligned
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_BLANK   <= 1'b0;
      oVGA_H_SYNC  <= 1'b1;
      oVGA_V_SYNC  <= 1'b1;
      oFrame_start <= 1'b0;
    end else begin
      oFrame_start <= enable && h_last && v_last;
      if (enable) begin
        h_cnt       <= h_last ? '0 : h_cnt + 10'd1;
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + 10'd1;
        oVGA_R      <= visible ? iRed : '0;
        oVGA_G      <= visible ? iGreen : '0;
        oVGA_B      <= visible ? iBlue : '0;
        oVGA_BLANK  <= visible;
        oVGA_H_SYNC <= h_sync_n;
        oVGA_V_SYNC <= v_sync_n;
      end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized scoreboard bench; a linear pixel-index model predicts every clock's outputs.
module tb_vga_timing_gen;
  localparam int HV = 40, HF = 4, HS = 8, HB = 6;
  localparam int VV = 20, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic enable = 1'b0;
  logic [7:0] ired = '0, igreen = '0, iblue = '0;
  logic [9:0] cx, cy;
  logic [7:0] r, g, b;
  logic hs, vs, sync, blank, fs;
  logic [48:0] q[$];
  int vectors = 0, miscompares = 0;
  int exp_frames = 0, got_frames = 0;
  bit running = 1'b0;
  int pos = 0;
  logic [7:0] er = '0, eg = '0, eb = '0;
  logic ehs = 1'b1, evs = 1'b1, ebl = 1'b0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .iRed(ired), .iGreen(igreen), .iBlue(iblue),
    .oCoord_X(cx), .oCoord_Y(cy),
    .oVGA_R(r), .oVGA_G(g), .oVGA_B(b),
    .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_SYNC(sync),
    .oVGA_BLANK(blank), .oFrame_start(fs)
  );

  always #5 clock = ~clock;

  function automatic logic [48:0] got_vec();
    return {cx, cy, r, g, b, hs, vs, blank, fs, sync};
  endfunction

  function automatic logic [48:0] exp_vec(input logic efs);
    return {10'(pos % HT), 10'(pos / HT), er, eg, eb, ehs, evs, ebl, efs, 1'b0};
  endfunction

  // called on a falling edge; predicts the state after the coming rising edge
  task automatic step(input logic en, input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    int x, y;
    logic wrap;
    enable = en; ired = rr; igreen = gg; iblue = bb;
    x = pos % HT;
    y = pos / HT;
    wrap = en && (pos == HT * VT - 1);
    if (en) begin
      ebl = (x < HV) && (y < VV);
      er  = ebl ? rr : 8'h00;
      eg  = ebl ? gg : 8'h00;
      eb  = ebl ? bb : 8'h00;
      ehs = !(x >= HV + HF && x < HV + HF + HS);
      evs = !(y >= VV + VF && y < VV + VF + VS);
      pos = (pos + 1) % (HT * VT);
    end
    if (wrap) exp_frames++;
    q.push_back(exp_vec(wrap));
    @(negedge clock);
  endtask

  task automatic do_reset();
    logic [48:0] e;
    resetn = 1'b0;
    #1;
    pos = 0; er = '0; eg = '0; eb = '0; ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
    e = exp_vec(1'b0);
    vectors++;
    if (got_vec() !== e) begin
      miscompares++;
      $display("FAIL async_reset got=%h required=%h", got_vec(), e);
    end
    q.push_back(e);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  always @(posedge clock) begin
    logic [48:0] e;
    #1;
    if (fs === 1'b1) got_frames++;
    if (q.size() == 0) begin
      if (running) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty got=%h required=<queued entry>", got_vec());
      end
    end else begin
      e = q.pop_front();
      vectors++;
      if (got_vec() !== e) begin
        miscompares++;
        $display("FAIL cycle t=%0t got x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b bl=%b fs=%b sy=%b required x=%0d y=%0d rgb=%h hs=%b vs=%b bl=%b fs=%b sy=%b",
          $time, cx, cy, r, g, b, hs, vs, blank, fs, sync,
          e[48:39], e[38:29], e[28:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    running = 1'b1;
    #2;
    do_reset();
    for (int i = 0; i < 2 * HT * VT * 2 + 200; i++)
      step(i[0] == 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 2000; i++)
      step(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 37; i++)
      step(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    step(1'b1, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < 700; i++)
      step(1'b1, 8'hFF, 8'hFF, 8'hFF);
    do_reset();
    for (int i = 0; i < 3 * HT; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 2 * HT * VT + 50; i++)
      step(1'b1, 8'(pos % HT), 8'($urandom), 8'($urandom));
    running = 1'b0;
    @(negedge clock);
    vectors++;
    if (got_frames != exp_frames || q.size() != 0) begin
      miscompares++;
      $display("FAIL frame_pulses got=%0d required=%0d (pending=%0d)", got_frames, exp_frames, q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
